peripheral_bus_master: RTL and testbench
========================================

Name: peripheral_bus_master

Overview:
- Initiator end of the peripheral bus: bridges a Wishbone classic slave port from the management core or CPU onto the shared peripheral bus.
- Issues one read or write at a time, honours responder `peripheralBus_busy`, registers read data and returns a single-cycle Wishbone acknowledge.
- Sits between the Wishbone interconnect and all peripheral responders (GPIO, UART, SPI, ...), which decode their own ID from `peripheralBus_address`.

Parameters:
- TIMEOUT_CYCLES, 255: busy cycles tolerated before abort (only with the optional feature); 8-bit counter, legal range 1..255.
- ERROR_DATA, 32'hDEADBEEF: value returned on `wb_data_o` for a timed-out read.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe.
- wb_we_i  input  1  Wishbone write enable.
- wb_sel_i  input  4  Wishbone byte select.
- wb_adr_i  input  24  byte address within peripheral space.
- wb_data_i  input  32  write data.
- wb_ack_o  output  1  transfer acknowledge, one cycle.
- wb_stall_o  output  1  high while a transfer is outstanding.
- wb_error_o  output  1  error acknowledge (timeout only).
- wb_data_o  output  32  registered read data.
- peripheralBus_we  output  1  write strobe.
- peripheralBus_oe  output  1  read strobe.
- peripheralBus_busy  input  1  responder not ready; holds the access.
- peripheralBus_address  output  24  address.
- peripheralBus_byteSelect  output  4  byte lanes.
- peripheralBus_dataWrite  output  32  write data.
- peripheralBus_dataRead  input  32  read data, valid while oe high and busy low.

Behaviour:
- Reset: all outputs 0; state IDLE; this applies on the cycle after `rst` is sampled high, including mid-access. No ack is issued for an access interrupted by reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Request is `wb_cyc_i & wb_stb_i`. On a sampled request, latch adr, sel, we and data_i into the bus output registers.
  - Assert `peripheralBus_we` (if we) or `peripheralBus_oe` (if !we), never both; go to ACCESS.
  - `wb_stall_o` = 0 only in IDLE.
- ACCESS:
  - Strobe, address, byteSelect and dataWrite are held stable.
  - Each edge samples `peripheralBus_busy`. If 0: drop we/oe; on reads capture `peripheralBus_dataRead` into `wb_data_o`; go to DONE.
  - If 1: stay in ACCESS.
  - If `wb_cyc_i` is sampled low in ACCESS: abort, drop strobes, go to IDLE, no ack.
- DONE:
  - `wb_ack_o` = 1 for exactly one cycle; return to IDLE.
  - A new request can be sampled on the following edge.
- `peripheralBus_dataWrite` is 0 during reads. `wb_data_o` holds its last value after writes and is not cleared.
- Latency with busy always 0:
  - strobe high 1 cycle after request sampled;
  - ack high 2 cycles after;
  - throughput of one transfer per 3 cycles.
- Each extra busy cycle adds 1 cycle of latency.
- Strobe is a level, not a pulse: a responder sees exactly one contiguous strobe interval per access.
- Back-to-back requests with `wb_stb_i` held high are never merged. Every accepted request produces exactly one ack (or error), or an abort.

Optional Feature:
- Macro: `PERIPHERAL_BUS_TIMEOUT_EN`.
- With the macro defined:
  - An 8-bit counter clears on entry to ACCESS and increments each cycle busy is sampled 1.
  - When the count reaches TIMEOUT_CYCLES with busy still 1: drop strobes; go to DONE asserting `wb_error_o` (not `wb_ack_o`) for one cycle.
  - On reads, `wb_data_o` = ERROR_DATA.
- Without the macro: no counter; ACCESS waits indefinitely; `wb_error_o` is tied 0.

Test Plan:
- Write: adr 24'h030010, sel 4'hF, data 32'h12345678, busy 0 -> we high exactly 1 cycle with those values; ack 2 cycles after request; oe never high.
- Read: adr 24'h030000, busy 0, dataRead 32'hA5A5_0003 -> oe high 1 cycle; `wb_data_o` = 32'hA5A50003 coincident with ack.
- Busy stall: read with busy held 1 for 5 cycles -> oe high 6 cycles with stable address; ack 7 cycles after request; `wb_stall_o` high throughout.
- Abort and reset: drop `wb_cyc_i` during busy -> strobes low next cycle, no ack. Separately, assert `rst` mid-ACCESS -> all outputs 0 next cycle, no ack.
- Back-to-back: two writes with `stb` held -> two distinct we intervals separated by at least 2 low cycles; exactly two acks.
- Timeout (macro defined, TIMEOUT_CYCLES=4): busy stuck 1 on a read -> oe drops after 4 busy cycles; `wb_error_o` pulses once; `wb_data_o` = 32'hDEADBEEF; `wb_ack_o` stays 0.

Source files
------------

// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave to peripheral bus initiator: one access at a time, honours responder busy.
// Optional busy timeout enabled by defining PERIPHERAL_BUS_TIMEOUT_EN.
module peripheral_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [23:0] wb_adr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_error_o,
    output logic [31:0] wb_data_o,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    input  logic        peripheralBus_busy,
    output logic [23:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state_q;
    logic        ack_q, stall_q, we_q, oe_q;
    logic [23:0] adr_q;
    logic [3:0]  sel_q;
    logic [31:0] wdata_q, rdata_q;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    logic        err_q;
    logic [7:0]  cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q   <= wb_adr_i;
                        sel_q   <= wb_sel_i;
                        wdata_q <= wb_we_i ? wb_data_i : 32'h0;
                        we_q    <= wb_we_i;
                        oe_q    <= !wb_we_i;
                        stall_q <= 1'b1;
                        state_q <= ACCESS;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // Abort wins over completion: the initiator has already given up.
                    if (!wb_cyc_i) begin
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        stall_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (!peripheralBus_busy) begin
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        if (oe_q) rdata_q <= peripheralBus_dataRead;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
                    else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        if (oe_q) rdata_q <= ERROR_DATA;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
`endif
                end
                DONE: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_ack_o                 = ack_q;
    assign wb_stall_o               = stall_q;
    assign wb_data_o                = rdata_q;
    assign peripheralBus_we         = we_q;
    assign peripheralBus_oe         = oe_q;
    assign peripheralBus_address    = adr_q;
    assign peripheralBus_byteSelect = sel_q;
    assign peripheralBus_dataWrite  = wdata_q;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    assign wb_error_o = err_q;
`else
    assign wb_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Scoreboard bench for peripheral_bus_master: strobe timing, latency, abort, reset, back-to-back, timeout.
module tb_peripheral_bus_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
    logic [3:0]  wb_sel_i = 0;
    logic [23:0] wb_adr_i = 0;
    logic [31:0] wb_data_i = 0;
    logic        wb_ack_o, wb_stall_o, wb_error_o;
    logic [31:0] wb_data_o;
    logic        peripheralBus_we, peripheralBus_oe;
    logic        peripheralBus_busy = 0;
    logic [23:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead = 0;

    peripheral_bus_master #(.TIMEOUT_CYCLES(4), .ERROR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
        .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .wb_error_o(wb_error_o), .wb_data_o(wb_data_o),
        .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
        .peripheralBus_busy(peripheralBus_busy), .peripheralBus_address(peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite(peripheralBus_dataWrite),
        .peripheralBus_dataRead(peripheralBus_dataRead)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_err; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [31:0] last_rd = 32'h0;

    // Response monitor: every ack/error must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (peripheralBus_we && peripheralBus_oe) begin
            errors++;
            $display("FAIL both_strobes: we=1 oe=1, required at most one");
        end
        if (wb_ack_o || wb_error_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response: ack=%0b err=%0b, required none", wb_ack_o, wb_error_o);
            end else begin
                e = sb.pop_front();
                if ({wb_error_o, wb_ack_o} !== {e.is_err, !e.is_err} || wb_data_o !== e.data) begin
                    errors++;
                    $display("FAIL response: err/ack=%b%b data=%h, required %b%b data=%h",
                             wb_error_o, wb_ack_o, wb_data_o, e.is_err, !e.is_err, e.data);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [31:0] rd, input int nbusy,
                          input logic exp_err, input logic [31:0] exp_data,
                          output int lat, output int scyc);
        logic [31:0] expw;
        expw = we ? wd : 32'h0;
        lat = 0; scyc = 0;
        sb.push_back('{exp_err, exp_data});
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel; wb_adr_i = adr; wb_data_i = wd;
        peripheralBus_dataRead = rd; peripheralBus_busy = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (peripheralBus_we || peripheralBus_oe) begin
                scyc++;
                checks++;
                if ({peripheralBus_we, peripheralBus_oe} !== {we, !we} || peripheralBus_address !== adr ||
                    peripheralBus_byteSelect !== sel || peripheralBus_dataWrite !== expw) begin
                    errors++;
                    $display("FAIL strobe_hold c=%0d: we/oe=%b%b adr=%h sel=%h dw=%h, required %b%b %h %h %h",
                             c, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                             peripheralBus_byteSelect, peripheralBus_dataWrite, we, !we, adr, sel, expw);
                end
            end
            checks++;
            if (wb_stall_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_busy c=%0d: stall=%b, required 1", c, wb_stall_o);
            end
            if (wb_ack_o || wb_error_o) begin lat = c; break; end
            peripheralBus_busy = (c <= nbusy);
        end
        if (lat == 0) begin
            errors++;
            $display("FAIL no_response: no ack within 200 cycles, required one");
        end
        wb_cyc_i = 0; wb_stb_i = 0; peripheralBus_busy = 0;
        @(negedge clk);
        checks++;
        if ({wb_stall_o, wb_ack_o, wb_error_o} !== 3'b000) begin
            errors++;
            $display("FAIL after_done: stall/ack/err=%b, required 000", {wb_stall_o, wb_ack_o, wb_error_o});
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wb_ack_o, wb_stall_o, wb_error_o, wb_data_o, peripheralBus_we, peripheralBus_oe,
             peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (data=%h adr=%h), required all 0",
                     wb_data_o, peripheralBus_address);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic check_timing(input string name, input int lat, input int scyc, input int elat, input int escyc);
        checks++;
        if (lat !== elat || scyc !== escyc) begin
            errors++;
            $display("FAIL %s: latency=%0d strobe_cycles=%0d, required %0d %0d", name, lat, scyc, elat, escyc);
        end
    endtask

    task automatic test_write();
        int lat, scyc;
        access(1'b1, 24'h030010, 4'hF, 32'h12345678, 32'h0, 0, 1'b0, last_rd, lat, scyc);
        check_timing("write_timing", lat, scyc, 2, 1);
        access(1'b1, 24'h030020, 4'h3, 32'h0000BEEF, 32'h0, 1, 1'b0, last_rd, lat, scyc);
        check_timing("write_busy1_timing", lat, scyc, 3, 2);
    endtask

    task automatic test_read();
        int lat, scyc;
        access(1'b0, 24'h030000, 4'hF, 32'h11111111, 32'hA5A50003, 0, 1'b0, 32'hA5A50003, lat, scyc);
        last_rd = 32'hA5A50003;
        check_timing("read_timing", lat, scyc, 2, 1);
        // A write afterwards must leave read data untouched.
        access(1'b1, 24'h030014, 4'hC, 32'h0F0F0F0F, 32'h0, 0, 1'b0, last_rd, lat, scyc);
        check_timing("write_after_read_timing", lat, scyc, 2, 1);
    endtask

    task automatic test_busy_stall();
        int lat, scyc;
        access(1'b0, 24'h030004, 4'h1, 32'h0, 32'h0BADF00D, 5, 1'b0, 32'h0BADF00D, lat, scyc);
        last_rd = 32'h0BADF00D;
        check_timing("busy5_timing", lat, scyc, 7, 6);
    endtask

    task automatic start_stuck_read(input logic [23:0] adr);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF; wb_adr_i = adr;
        peripheralBus_dataRead = 32'h77777777; peripheralBus_busy = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (peripheralBus_oe !== 1'b1 || wb_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL stuck_read_active: oe=%b stall=%b, required 1 1", peripheralBus_oe, wb_stall_o);
        end
    endtask

    task automatic quiet_cycles(input string name, input int n);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (wb_ack_o || wb_error_o || peripheralBus_oe || peripheralBus_we) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s: %0d cycles with ack/err/strobe, required 0", name, seen);
        end
    endtask

    task automatic test_abort();
        start_stuck_read(24'h030008);
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);
        checks++;
        if ({peripheralBus_oe, peripheralBus_we, wb_stall_o, wb_ack_o} !== 4'b0000) begin
            errors++;
            $display("FAIL abort: oe/we/stall/ack=%b, required 0000",
                     {peripheralBus_oe, peripheralBus_we, wb_stall_o, wb_ack_o});
        end
        peripheralBus_busy = 0;
        quiet_cycles("abort_no_ack", 4);
    endtask

    task automatic test_reset_mid_access();
        start_stuck_read(24'h03000C);
        rst = 1;
        @(negedge clk);
        checks++;
        if ({wb_ack_o, wb_stall_o, wb_error_o, wb_data_o, peripheralBus_we, peripheralBus_oe,
             peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite} !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: data=%h adr=%h oe=%b stall=%b, required all 0",
                     wb_data_o, peripheralBus_address, peripheralBus_oe, wb_stall_o);
        end
        rst = 0; wb_cyc_i = 0; wb_stb_i = 0; peripheralBus_busy = 0;
        last_rd = 32'h0;
        quiet_cycles("reset_no_ack", 4);
    endtask

    task automatic test_back_to_back();
        int n_we = 0, gap = 0, min_gap = 99, acks = 0;
        logic prev = 1'b0;
        sb.push_back('{1'b0, last_rd});
        sb.push_back('{1'b0, last_rd});
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF; wb_adr_i = 24'h030030;
        wb_data_i = 32'hCAFE0001; peripheralBus_busy = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (peripheralBus_we && !prev) begin
                n_we++;
                if (n_we > 1 && gap < min_gap) min_gap = gap;
            end
            if (peripheralBus_we) gap = 0; else gap++;
            prev = peripheralBus_we;
            if (wb_ack_o) begin
                acks++;
                if (acks == 2) begin wb_cyc_i = 0; wb_stb_i = 0; end
            end
        end
        checks++;
        if (n_we != 2 || min_gap < 2 || acks != 2) begin
            errors++;
            $display("FAIL back_to_back: we_intervals=%0d min_gap=%0d acks=%0d, required 2 >=2 2",
                     n_we, min_gap, acks);
        end
    endtask

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int lat, scyc;
        access(1'b0, 24'h030040, 4'hF, 32'h0, 32'h12121212, 1000, 1'b1, 32'hDEADBEEF, lat, scyc);
        last_rd = 32'hDEADBEEF;
        check_timing("timeout_timing", lat, scyc, 5, 4);
    endtask
`else
    task automatic test_long_busy();
        int lat, scyc;
        access(1'b0, 24'h030040, 4'hF, 32'h0, 32'h13579BDF, 20, 1'b0, 32'h13579BDF, lat, scyc);
        last_rd = 32'h13579BDF;
        check_timing("long_busy_timing", lat, scyc, 22, 21);
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_stall();
        test_abort();
        test_reset_mid_access();
        test_back_to_back();
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_long_busy();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
